// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates ALU/LSU writebacks onto one registered register-file write port and scoreboards pending destinations.
// Accepted write appears one cycle later for one cycle; define WB_ARB_RR_EN for round-robin contention, otherwise LSU always wins.
module wb_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_val,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_val,
    output logic        lsu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    output logic        stall,
    output logic [4:0]  rd_addr,
    output logic [31:0] w_val
);

    logic        both;
    logic        alu_win;
    logic [31:0] busy;
    logic [31:0] busy_nxt;

    assign both = alu_valid & lsu_valid;

`ifdef WB_ARB_RR_EN
    // Set when the LSU took the most recent contended grant.
    logic last_lsu;

    assign alu_win = last_lsu;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_lsu <= 1'b0;
        end else if (both) begin
            last_lsu <= ~last_lsu;
        end
    end
`else
    assign alu_win = 1'b0;
`endif

    assign alu_ready = ~reset & alu_valid & (~lsu_valid | alu_win);
    assign lsu_ready = ~reset & lsu_valid & (~alu_valid | ~alu_win);

    // Idle cycles drive index 0 so the register file write is harmless.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_addr <= 5'd0;
            w_val   <= 32'd0;
        end else if (alu_ready) begin
            rd_addr <= alu_rd;
            w_val   <= alu_val;
        end else if (lsu_ready) begin
            rd_addr <= lsu_rd;
            w_val   <= lsu_val;
        end else begin
            rd_addr <= 5'd0;
            w_val   <= 32'd0;
        end
    end

    // No bypass: a register stays busy through the cycle its value is being written.
    assign stall = busy[id_rs1] | busy[id_rs2] | busy[issue_rd];

    always_comb begin
        busy_nxt = busy;
        if (rd_addr != 5'd0) begin
            busy_nxt[rd_addr] = 1'b0;
        end
        if (issue_valid && !stall && issue_rd != 5'd0) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: vector table plus hand sequences; expected writes are queued and compared one cycle later.
module tb_wb_arbiter;

`ifdef WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] aval;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] lval;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_ar;
        logic        e_lr;
        logic        e_st;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } wr_t;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_val;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_val;
    logic        lsu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        stall;
    logic [4:0]  rd_addr;
    logic [31:0] w_val;

    int checks   = 0;
    int failures = 0;

    vec_t tbl[$];
    wr_t  sb[$];

    wb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_val     (alu_val),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_val     (lsu_val),
        .lsu_ready   (lsu_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .stall       (stall),
        .rd_addr     (rd_addr),
        .w_val       (w_val)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] aval,
        input logic lv, input logic [4:0] lrd, input logic [31:0] lval,
        input logic iv, input logic [4:0] ird, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic e_ar, input logic e_lr, input logic e_st, input logic [4:0] e_rd, input logic [31:0] e_val);
        vec_t v;
        v.rst = rst;   v.av = av;     v.ard = ard;   v.aval = aval;
        v.lv = lv;     v.lrd = lrd;   v.lval = lval;
        v.iv = iv;     v.ird = ird;   v.rs1 = rs1;   v.rs2 = rs2;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_st = e_st; v.e_rd = e_rd; v.e_val = e_val;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle, check combinational outputs, then check the registered write it produced.
    task automatic apply(input vec_t v, input string nm);
        wr_t w;
        wr_t got;
        reset       = v.rst;
        alu_valid   = v.av;
        alu_rd      = v.ard;
        alu_val     = v.aval;
        lsu_valid   = v.lv;
        lsu_rd      = v.lrd;
        lsu_val     = v.lval;
        issue_valid = v.iv;
        issue_rd    = v.ird;
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        #2;
        check({nm, ".alu_ready"}, {31'd0, alu_ready}, {31'd0, v.e_ar});
        check({nm, ".lsu_ready"}, {31'd0, lsu_ready}, {31'd0, v.e_lr});
        check({nm, ".stall"}, {31'd0, stall}, {31'd0, v.e_st});
        w.rd  = v.e_rd;
        w.val = v.e_val;
        sb.push_back(w);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        check({nm, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, got.rd});
        check({nm, ".w_val"}, w_val, got.val);
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_val = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_val = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        repeat (2) @(posedge clock);
        #1;

        // rst av ard aval | lv lrd lval | iv ird rs1 rs2 | ar lr st | rd val
        tbl.push_back(mk(1, 1, 5, 32'hAAAA0005, 1, 6, 32'hBBBB0006, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 5, 32'h12345678, 0, 0, 32'h0, 0, 0, 0, 0, 1, 0, 0, 5, 32'h12345678));
        tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0, 1, 6, 32'h66, 0, 0, 0, 0, 0, 1, 0, 6, 32'h66));
        tbl.push_back(mk(0, 1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0, 0, 1, 0, 4, 32'h44));
        tbl.push_back(mk(0, 1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0, RR, !RR, 0, RR ? 5'd3 : 5'd4, RR ? 32'h33 : 32'h44));
        tbl.push_back(mk(0, 1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0, 0, 1, 0, 4, 32'h44));
        tbl.push_back(mk(0, 1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0, RR, !RR, 0, RR ? 5'd3 : 5'd4, RR ? 32'h33 : 32'h44));
        tbl.push_back(mk(0, 1, 0, 32'hDEAD, 0, 0, 32'h0, 1, 0, 0, 0, 1, 0, 0, 0, 32'hDEAD));
        tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 7, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0, 1, 7, 32'h77, 0, 0, 7, 0, 0, 1, 1, 7, 32'h77));
        tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 7, 0, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 7, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 10, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 8, 0, 10, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 8, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 10, 0, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 1, 9, 32'h99, 0, 0, 32'h0, 0, 0, 0, 0, 1, 0, 0, 9, 32'h99));
        tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 9, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 9, 0, 0, 1, 0, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Reset one cycle after an acceptance with busy[2] set.
        apply(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0), "rst_set2");
        apply(mk(0, 1, 11, 32'hB1, 0, 0, 32'h0, 0, 0, 2, 0, 1, 0, 1, 11, 32'hB1), "rst_acc");
        apply(mk(1, 1, 12, 32'hC2, 1, 13, 32'hD3, 0, 0, 2, 0, 0, 0, 1, 0, 32'h0), "rst_mid");
        apply(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 2, 0, 0, 0, 0, 0, 32'h0), "rst_after");

        // Contention after reset; a lone grant must not move the last-grant state.
        apply(mk(0, 1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0, 0, 1, 0, 4, 32'h44), "rr_a");
        apply(mk(0, 1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0, RR, !RR, 0, RR ? 5'd3 : 5'd4, RR ? 32'h33 : 32'h44), "rr_b");
        apply(mk(0, 0, 0, 32'h0, 1, 4, 32'h45, 0, 0, 0, 0, 0, 1, 0, 4, 32'h45), "rr_lone");
        apply(mk(0, 1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0, 0, 1, 0, 4, 32'h44), "rr_c");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (5-bit register index, 32-bit data).
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 alu_valid / alu_rd / alu_val  in  1/5/32  ALU writeback request, destination index, result.
REQ-005 alu_ready  out  1  ALU request accepted this cycle.
REQ-006 lsu_valid / lsu_rd / lsu_val  in  1/5/32  load-unit writeback request, destination index, data.
REQ-007 lsu_ready  out  1  LSU request accepted this cycle.
REQ-008 issue_valid / issue_rd  in  1/5  decode issues an instruction that will write issue_rd.
REQ-009 id_rs1 / id_rs2  in  5/5  source indices of the instruction in decode.
REQ-010 stall  out  1  decode hazard; instruction must not issue.
REQ-011 rd_addr / w_val  out  5/32  single write port driven into the register file, which writes every cycle.

Function
REQ-012 Handshake: a request is accepted when valid and ready are both high in the same cycle; ready is combinational from valid and arbitration state.
REQ-013 At most one of alu_ready/lsu_ready SHALL be high per cycle; a lone valid requester is always granted.
REQ-014 Both valid: winner per REQ-030; loser's ready low; loser must hold request stable until accepted.
REQ-015 Latency: accepted rd/val SHALL appear on rd_addr/w_val on the next cycle, registered, and be held exactly one cycle.
REQ-016 Idle cycle (no acceptance): rd_addr SHALL be registered as 0, w_val as 0, so the register file performs no write.
REQ-017 Requests with rd=0 SHALL be accepted normally and produce rd_addr=0 (harmless).
REQ-018 Scoreboard: 32-bit busy vector; bit 0 permanently 0.
REQ-019 Set: issue_valid & !stall & issue_rd!=0 sets busy[issue_rd] at the clock edge.
REQ-020 Clear: busy[rd_addr] cleared at the edge where rd_addr (registered output, nonzero) is written into the register file.
REQ-021 Simultaneous set and clear of same index: set wins (busy stays 1).
REQ-022 stall = busy[id_rs1] | busy[id_rs2] | busy[issue_rd], combinational; x0 never stalls.
REQ-023 issue_valid while stall high SHALL be ignored (no scoreboard change).
REQ-024 stall SHALL NOT be suppressed by a same-cycle clear (no bypass); value readable from regfile the cycle after clear.
REQ-025 Arbitration state: 1-bit last-grant register, updated only on a contended grant (both valid).

Reset
REQ-026 In reset: alu_ready=0, lsu_ready=0, no acceptance regardless of valid.
REQ-027 After reset edge: rd_addr=0, w_val=0, busy=all zero, stall=0 (given no busy), last-grant=ALU (LSU favoured next).
REQ-028 Reset mid-operation SHALL discard any registered pending write (rd_addr forced 0) and all busy bits.

Configuration
REQ-029 Macro WB_ARB_RR_EN selects the contention policy.
REQ-030 Defined: round-robin, winner is the requester not granted at the last contended grant; undefined: fixed priority, LSU always wins; last-grant register absent.

Verification
REQ-031 Reset, then alu_valid=1 rd=5 val=0x12345678 alone -> alu_ready=1 same cycle; next cycle rd_addr=5, w_val=0x12345678; following cycle rd_addr=0.
REQ-032 Both valid continuously (alu rd=3, lsu rd=4), RR enabled -> grants alternate LSU, ALU, LSU, ...; RR disabled -> LSU granted every cycle, ALU never while LSU valid.
REQ-033 issue_valid rd=7 accepted; next cycle id_rs1=7 -> stall=1; LSU writes rd=7 -> stall stays 1 through the cycle rd_addr=7 is driven, drops to 0 the cycle after.
REQ-034 issue_rd=0 and id_rs1=id_rs2=0 with issue_valid -> stall=0 always, busy unchanged; ALU request rd=0 -> rd_addr=0 next cycle.
REQ-035 Same edge rd_addr=9 committing and issue_valid rd=9 -> busy[9] remains 1, stall on id_rs2=9.
REQ-036 Set busy[2], accept ALU request, then assert reset one cycle -> rd_addr=0, stall=0 for id_rs1=2, ready outputs 0 during reset.
